exe_mem_req: RTL and testbench
==============================

Name: exe_mem_req

Overview:
- EXE-stage data-SRAM request issuer, directly upstream of the MEM stage, which consumes the SRAM data_ok/rdata handshake.
- Holds the EXE pipeline register for memory fields and detects address-misaligned (ALE) exceptions.
- Issues load/store requests on the req/addr_ok channel and generates the SRAM size, wstrb and wdata encodings.
- Tracks requests orphaned by a MEM-stage flush and filters their late data_ok so MEM never pairs a stale response with a new instruction.

Parameters:
CANCEL_W, 2, width of the discard counter; at most 2^CANCEL_W-1 cancelled requests outstanding

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
id_to_exe_valid  in  1  upstream valid
exe_allowin  out  1  EXE may accept new instruction
in_load  in  1  instruction is a load
in_store  in  1  instruction is a store
in_size  in  2  01 byte, 10 half, 11 word (00 = no memory op)
in_addr  in  32  effective address (ALU result)
in_wdata  in  32  store data (rkd)
in_excp  in  1  exception already raised upstream
in_pc  in  32  instruction PC
mem_allowin  in  1  MEM stage allowin
flush  in  1  MEM exception/ertn/refetch flush
exe_to_mem_valid  out  1  EXE output valid
out_load  out  1  registered in_load
out_store  out  1  registered in_store
out_size  out  2  registered in_size
out_addr  out  32  registered address, also BADV on ALE
out_excp  out  1  in_excp or ALE
out_ale  out  1  ALE detected
out_pc  out  32  registered PC
data_sram_req  out  1  request valid
data_sram_wr  out  1  1 = store
data_sram_size  out  2  00 byte, 01 half, 10 word
data_sram_wstrb  out  4  byte enables (0000 for loads)
data_sram_addr  out  32  request address
data_sram_wdata  out  32  replicated store data
data_sram_addr_ok  in  1  request accepted
data_sram_data_ok  in  1  response from bridge
mem_data_ok  out  1  filtered data_ok delivered to MEM
discard_cnt  out  CANCEL_W  cancelled-request count (debug/verif)

Behaviour:
- Reset (resetn=0 at posedge): exe_valid=0, mem_pending=0, discard_cnt=0. All outputs combinational from these are then 0: req, exe_to_mem_valid, mem_data_ok. The SRAM bridge is reset on the same resetn, so no responses from before reset arrive afterwards.
- Pipeline register:
  - Loaded when exe_allowin & id_to_exe_valid.
  - exe_valid <= id_to_exe_valid when exe_allowin.
  - flush clears exe_valid (flush has priority over load).
- is_mem = exe_valid & (out_load|out_store).
- ALE = is_mem & ~in_excp_r & ((size==10 & addr[0]) | (size==11 & addr[1:0]!=0)).
- out_excp = in_excp_r | ALE.
- data_sram_req = is_mem & ~out_excp & mem_allowin & ~flush & (discard_cnt != all-ones).
- exe_ready_go = ~is_mem | out_excp | (data_sram_req & data_sram_addr_ok). Handshake and transfer to MEM coincide, so no separate issued flag exists. req stays high with stable payload until addr_ok unless flush or mem_allowin drops.
- exe_allowin = ~exe_valid | (exe_ready_go & mem_allowin).
- exe_to_mem_valid = exe_valid & exe_ready_go & ~flush.
- Encoding:
  - size 01 -> sram 00, wstrb = 0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - size 10 -> sram 01, wstrb = 0011<<{addr[1],0}, wdata = {2{wdata[15:0]}}.
  - size 11 -> sram 10, wstrb = 1111, wdata unchanged.
  - Loads: wstrb = 0000.
- mem_pending: 1 while the MEM-stage instruction owns an unreturned response.
  - Set on req & addr_ok.
  - Cleared on mem_data_ok.
  - Set and clear in the same cycle -> stays 1 (the new request is pending).
- Flush with mem_pending=1 and no mem_data_ok that cycle:
  - discard_cnt += 1 and mem_pending <= 0.
  - If data_ok arrives in the flush cycle while discard_cnt==0, it belongs to the flushed instruction. It is consumed: not counted, not forwarded.
- Filtering:
  - mem_data_ok = data_sram_data_ok & (discard_cnt==0) & ~flush.
  - data_ok while discard_cnt>0 -> discard_cnt -= 1, nothing forwarded.
  - Increment and decrement in the same cycle -> counter unchanged.
- Saturation: at discard_cnt == 2^CANCEL_W-1, new requests are held off; the counter never wraps.

Test Plan:
- Aligned word store, addr=0x1C000104, wdata=0xA5A5_1234, addr_ok same cycle -> req=1, wr=1, size=10, wstrb=1111; exe_to_mem_valid=1 that cycle.
- Byte store addr=0x...03, wdata=0x000000EE -> wstrb=1000, wdata=0xEEEEEEEE. Half load addr=0x...02 -> size=01, wstrb=0000.
- Half load addr=0x...01 -> out_ale=1, out_excp=1, req=0, out_addr=0x...01, advances next cycle. Word at 0x...02 gives the same response.
- Load accepted, flush asserted 2 cycles later before data_ok -> discard_cnt=1. Next load issued. First data_ok swallowed (mem_data_ok=0, cnt->0). Second data_ok forwarded.
- mem_allowin=0 with pending load -> req=0, exe_allowin=0. Release -> req asserts; addr_ok held low 3 cycles -> payload stable, no advance until addr_ok.
- Three flushed outstanding loads (cnt=3, CANCEL_W=2) -> new req blocked. One data_ok -> cnt=2, req resumes. resetn low mid-sequence -> cnt=0, valid=0 next cycle.

Source files
------------

// File: rtl/exe_mem_req.sv
// EXE-stage data-SRAM request issuer: holds the EXE memory fields, flags misaligned
// accesses, drives req/addr_ok, and filters responses that belong to flushed requests.
module exe_mem_req #(
    parameter int CANCEL_W = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                id_to_exe_valid,
    output logic                exe_allowin,
    input  logic                in_load,
    input  logic                in_store,
    input  logic [1:0]          in_size,
    input  logic [31:0]         in_addr,
    input  logic [31:0]         in_wdata,
    input  logic                in_excp,
    input  logic [31:0]         in_pc,
    input  logic                mem_allowin,
    input  logic                flush,
    output logic                exe_to_mem_valid,
    output logic                out_load,
    output logic                out_store,
    output logic [1:0]          out_size,
    output logic [31:0]         out_addr,
    output logic                out_excp,
    output logic                out_ale,
    output logic [31:0]         out_pc,
    output logic                data_sram_req,
    output logic                data_sram_wr,
    output logic [1:0]          data_sram_size,
    output logic [3:0]          data_sram_wstrb,
    output logic [31:0]         data_sram_addr,
    output logic [31:0]         data_sram_wdata,
    input  logic                data_sram_addr_ok,
    input  logic                data_sram_data_ok,
    output logic                mem_data_ok,
    output logic [CANCEL_W-1:0] discard_cnt
);

    localparam logic [CANCEL_W-1:0] CNT_MAX = '1;

    logic                r_exe_valid;
    logic                r_load;
    logic                r_store;
    logic [1:0]          r_size;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic                r_excp;
    logic [31:0]         r_pc;
    logic                r_mem_pending;
    logic [CANCEL_W-1:0] r_discard_cnt;

    logic                w_is_mem;
    logic                w_ale;
    logic                w_excp;
    logic                w_ready_go;
    logic                w_handshake;
    logic                w_cnt_zero;
    logic                w_cnt_full;
    logic                w_orphan;
    logic                w_drop_old;
    logic [1:0]          w_sram_size;
    logic [3:0]          w_wstrb;
    logic [31:0]         w_wdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_exe_valid <= 1'b0;
        end else if (flush) begin
            r_exe_valid <= 1'b0;
        end else if (exe_allowin) begin
            r_exe_valid <= id_to_exe_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (exe_allowin && id_to_exe_valid) begin
            r_load  <= in_load;
            r_store <= in_store;
            r_size  <= in_size;
            r_addr  <= in_addr;
            r_wdata <= in_wdata;
            r_excp  <= in_excp;
            r_pc    <= in_pc;
        end
    end

    assign w_is_mem = r_exe_valid & (r_load | r_store);
    assign w_ale    = w_is_mem & ~r_excp &
                      (((r_size == 2'b10) & r_addr[0]) |
                       ((r_size == 2'b11) & (r_addr[1:0] != 2'b00)));
    assign w_excp   = r_excp | w_ale;

    assign w_cnt_zero = (r_discard_cnt == '0);
    assign w_cnt_full = (r_discard_cnt == CNT_MAX);

    // Requests are held off once the discard counter is full so it can never wrap.
    assign data_sram_req    = w_is_mem & ~w_excp & mem_allowin & ~flush & ~w_cnt_full;
    assign w_handshake      = data_sram_req & data_sram_addr_ok;
    assign w_ready_go       = ~w_is_mem | w_excp | w_handshake;
    assign exe_allowin      = ~r_exe_valid | (w_ready_go & mem_allowin);
    assign exe_to_mem_valid = r_exe_valid & w_ready_go & ~flush;

    always_comb begin
        w_sram_size = 2'b00;
        w_wstrb     = 4'b0000;
        w_wdata     = r_wdata;
        case (r_size)
            2'b01: begin
                w_sram_size = 2'b00;
                w_wstrb     = 4'b0001 << r_addr[1:0];
                w_wdata     = {4{r_wdata[7:0]}};
            end
            2'b10: begin
                w_sram_size = 2'b01;
                w_wstrb     = 4'b0011 << {r_addr[1], 1'b0};
                w_wdata     = {2{r_wdata[15:0]}};
            end
            2'b11: begin
                w_sram_size = 2'b10;
                w_wstrb     = 4'b1111;
            end
            default: begin
                w_sram_size = 2'b00;
                w_wstrb     = 4'b0000;
            end
        endcase
        if (!r_store) begin
            w_wstrb = 4'b0000;
        end
    end

    assign data_sram_wr    = r_store;
    assign data_sram_size  = w_sram_size;
    assign data_sram_wstrb = w_wstrb;
    assign data_sram_addr  = r_addr;
    assign data_sram_wdata = w_wdata;

    assign mem_data_ok = data_sram_data_ok & w_cnt_zero & ~flush;

    // A flush orphans the pending request unless its own response lands in the same cycle.
    assign w_orphan   = flush & r_mem_pending & ~(data_sram_data_ok & w_cnt_zero) & ~w_cnt_full;
    assign w_drop_old = data_sram_data_ok & ~w_cnt_zero;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_mem_pending <= 1'b0;
        end else if (w_handshake) begin
            r_mem_pending <= 1'b1;
        end else if (flush || mem_data_ok) begin
            r_mem_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_discard_cnt <= '0;
        end else begin
            case ({w_orphan, w_drop_old})
                2'b10:   r_discard_cnt <= r_discard_cnt + 1'b1;
                2'b01:   r_discard_cnt <= r_discard_cnt - 1'b1;
                default: r_discard_cnt <= r_discard_cnt;
            endcase
        end
    end

    assign out_load    = r_load;
    assign out_store   = r_store;
    assign out_size    = r_size;
    assign out_addr    = r_addr;
    assign out_excp    = w_excp;
    assign out_ale     = w_ale;
    assign out_pc      = r_pc;
    assign discard_cnt = r_discard_cnt;

endmodule

// File: tb/tb_exe_mem_req.sv
// Bench for exe_mem_req: an in-order response queue model (live vs orphaned requests)
// checked every cycle, plus directed literal expectations.
module tb_exe_mem_req;

    logic        clk = 1'b0;
    logic        resetn;
    logic        id_to_exe_valid;
    logic        exe_allowin;
    logic        in_load;
    logic        in_store;
    logic [1:0]  in_size;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        in_excp;
    logic [31:0] in_pc;
    logic        mem_allowin;
    logic        flush;
    logic        exe_to_mem_valid;
    logic        out_load;
    logic        out_store;
    logic [1:0]  out_size;
    logic [31:0] out_addr;
    logic        out_excp;
    logic        out_ale;
    logic [31:0] out_pc;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic        mem_data_ok;
    logic [1:0]  discard_cnt;

    always #5 clk = ~clk;

    exe_mem_req #(.CANCEL_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .id_to_exe_valid(id_to_exe_valid), .exe_allowin(exe_allowin),
        .in_load(in_load), .in_store(in_store), .in_size(in_size),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_excp(in_excp), .in_pc(in_pc),
        .mem_allowin(mem_allowin), .flush(flush),
        .exe_to_mem_valid(exe_to_mem_valid),
        .out_load(out_load), .out_store(out_store), .out_size(out_size),
        .out_addr(out_addr), .out_excp(out_excp), .out_ale(out_ale), .out_pc(out_pc),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .mem_data_ok(mem_data_ok), .discard_cnt(discard_cnt)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // model state: the EXE entry and the queue of outstanding responses (1 = live, 0 = orphan)
    bit          m_valid = 1'b0;
    bit          m_load, m_store, m_excp;
    int unsigned m_size;
    logic [31:0] m_addr, m_wdata, m_pc;
    bit          q[$];

    bit          e_ale, e_excp, e_req, e_acc, e_allowin, e_tomem, e_mdok;
    int          e_cnt;
    logic [1:0]  e_size;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        bit is_mem, mis, done;
        int n;
        n = 0;
        foreach (q[i]) if (!q[i]) n++;
        e_cnt     = n;
        is_mem    = m_valid && (m_load || m_store);
        mis       = (m_size == 2 && (m_addr % 2) != 0) || (m_size == 3 && (m_addr % 4) != 0);
        e_ale     = is_mem && !m_excp && mis;
        e_excp    = m_excp || e_ale;
        e_req     = is_mem && !e_excp && (mem_allowin === 1'b1) && (flush === 1'b0) && n < 3;
        e_acc     = e_req && (data_sram_addr_ok === 1'b1);
        done      = !is_mem || e_excp || e_acc;
        e_allowin = !m_valid || (done && (mem_allowin === 1'b1));
        e_tomem   = m_valid && done && (flush === 1'b0);
        e_mdok    = (data_sram_data_ok === 1'b1) && q.size() > 0 && q[0] && (flush === 1'b0);
        e_size    = 2'(m_size - 1);
        if (!m_store)         e_wstrb = 4'h0;
        else if (m_size == 1) e_wstrb = 4'(1 << (m_addr % 4));
        else if (m_size == 2) e_wstrb = 4'(3 << (m_addr & 2));
        else                  e_wstrb = 4'hF;
        if (m_size == 1)      e_wdata = (m_wdata & 32'hFF) * 32'h01010101;
        else if (m_size == 2) e_wdata = (m_wdata & 32'hFFFF) * 32'h00010001;
        else                  e_wdata = m_wdata;
    endtask

    always @(posedge clk) begin
        model_eval();
        if (resetn === 1'b0) begin
            m_valid = 1'b0;
            q.delete();
        end else begin
            if (data_sram_data_ok === 1'b1 && q.size() > 0) void'(q.pop_front());
            if (flush === 1'b1) foreach (q[i]) q[i] = 1'b0;
            if (e_acc) q.push_back(1'b1);
            if (e_allowin && id_to_exe_valid === 1'b1) begin
                m_load  = in_load;
                m_store = in_store;
                m_size  = int'(in_size);
                m_addr  = in_addr;
                m_wdata = in_wdata;
                m_excp  = in_excp;
                m_pc    = in_pc;
            end
            if (flush === 1'b1)  m_valid = 1'b0;
            else if (e_allowin)  m_valid = id_to_exe_valid;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            model_eval();
            check("cmp_allowin", 32'(exe_allowin), 32'(e_allowin));
            check("cmp_tomem", 32'(exe_to_mem_valid), 32'(e_tomem));
            check("cmp_req", 32'(data_sram_req), 32'(e_req));
            check("cmp_mdok", 32'(mem_data_ok), 32'(e_mdok));
            check("cmp_cnt", 32'(discard_cnt), 32'(e_cnt));
            if (m_valid) begin
                check("cmp_out_load", 32'(out_load), 32'(m_load));
                check("cmp_out_store", 32'(out_store), 32'(m_store));
                check("cmp_out_size", 32'(out_size), m_size);
                check("cmp_out_addr", out_addr, m_addr);
                check("cmp_out_pc", out_pc, m_pc);
                check("cmp_ale", 32'(out_ale), 32'(e_ale));
                check("cmp_excp", 32'(out_excp), 32'(e_excp));
            end
            if (e_req) begin
                check("cmp_wr", 32'(data_sram_wr), 32'(m_store));
                check("cmp_addr", data_sram_addr, m_addr);
                check("cmp_size", 32'(data_sram_size), 32'(e_size));
                check("cmp_wstrb", 32'(data_sram_wstrb), 32'(e_wstrb));
                check("cmp_wdata", data_sram_wdata, e_wdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_id(input bit ld, input bit st, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] d);
        id_to_exe_valid = 1'b1;
        in_load  = ld;
        in_store = st;
        in_size  = sz;
        in_addr  = a;
        in_wdata = d;
        in_excp  = 1'b0;
        in_pc    = a ^ 32'h0000_8000;
    endtask

    task automatic issue(input bit ld, input bit st, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        load_id(ld, st, sz, a, d);
        step();
        id_to_exe_valid = 1'b0;
    endtask

    task automatic respond();
        data_sram_data_ok = 1'b1;
        step();
        data_sram_data_ok = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; id_to_exe_valid = 1'b0;
        in_load = 1'b0; in_store = 1'b0; in_size = 2'b00; in_addr = '0;
        in_wdata = '0; in_excp = 1'b0; in_pc = '0;
        mem_allowin = 1'b1; flush = 1'b0;
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;

        step();
        chk_en = 1'b1;
        #1;
        check("rst_allowin", 32'(exe_allowin), 32'd1);
        check("rst_tomem", 32'(exe_to_mem_valid), 32'd0);
        check("rst_req", 32'(data_sram_req), 32'd0);
        check("rst_cnt", 32'(discard_cnt), 32'd0);
        step();
        resetn = 1'b1;
        step();

        // aligned word store, accepted immediately
        issue(1'b0, 1'b1, 2'b11, 32'h1C000104, 32'hA5A51234);
        data_sram_addr_ok = 1'b1;
        #1;
        check("w_req", 32'(data_sram_req), 32'd1);
        check("w_wr", 32'(data_sram_wr), 32'd1);
        check("w_size", 32'(data_sram_size), 32'd2);
        check("w_wstrb", 32'(data_sram_wstrb), 32'hF);
        check("w_wdata", data_sram_wdata, 32'hA5A51234);
        check("w_tomem", 32'(exe_to_mem_valid), 32'd1);
        step();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        #1;
        check("w_mdok", 32'(mem_data_ok), 32'd1);
        step();
        data_sram_data_ok = 1'b0;

        // byte store at offset 3, then half load at offset 2
        issue(1'b0, 1'b1, 2'b01, 32'h1C000103, 32'h000000EE);
        data_sram_addr_ok = 1'b1;
        #1;
        check("b_wstrb", 32'(data_sram_wstrb), 32'h8);
        check("b_wdata", data_sram_wdata, 32'hEEEEEEEE);
        check("b_size", 32'(data_sram_size), 32'd0);
        step();
        data_sram_addr_ok = 1'b0;
        respond();
        issue(1'b1, 1'b0, 2'b10, 32'h1C000102, 32'h12345678);
        data_sram_addr_ok = 1'b1;
        #1;
        check("h_size", 32'(data_sram_size), 32'd1);
        check("h_wstrb", 32'(data_sram_wstrb), 32'h0);
        check("h_wr", 32'(data_sram_wr), 32'd0);
        step();
        data_sram_addr_ok = 1'b0;
        respond();

        // misaligned accesses raise ALE and pass straight through
        issue(1'b1, 1'b0, 2'b10, 32'h1C000101, 32'h0);
        #1;
        check("ale_h_ale", 32'(out_ale), 32'd1);
        check("ale_h_excp", 32'(out_excp), 32'd1);
        check("ale_h_req", 32'(data_sram_req), 32'd0);
        check("ale_h_addr", out_addr, 32'h1C000101);
        check("ale_h_tomem", 32'(exe_to_mem_valid), 32'd1);
        step();
        #1;
        check("ale_h_gone", 32'(exe_to_mem_valid), 32'd0);
        issue(1'b1, 1'b0, 2'b11, 32'h1C000102, 32'h0);
        #1;
        check("ale_w_ale", 32'(out_ale), 32'd1);
        check("ale_w_req", 32'(data_sram_req), 32'd0);
        check("ale_w_tomem", 32'(exe_to_mem_valid), 32'd1);
        step();

        // flush orphans a pending load; its late data_ok is swallowed
        issue(1'b1, 1'b0, 2'b11, 32'h1C000200, 32'h0);
        data_sram_addr_ok = 1'b1;
        step();
        data_sram_addr_ok = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check("fl_cnt1", 32'(discard_cnt), 32'd1);
        issue(1'b1, 1'b0, 2'b11, 32'h1C000204, 32'h0);
        data_sram_addr_ok = 1'b1;
        step();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        #1;
        check("fl_swallow", 32'(mem_data_ok), 32'd0);
        step();
        #1;
        check("fl_cnt0", 32'(discard_cnt), 32'd0);
        check("fl_fwd", 32'(mem_data_ok), 32'd1);
        step();
        data_sram_data_ok = 1'b0;

        // response in the flush cycle with empty counter is consumed, not counted
        issue(1'b1, 1'b0, 2'b11, 32'h1C000210, 32'h0);
        data_sram_addr_ok = 1'b1;
        step();
        data_sram_addr_ok = 1'b0;
        flush = 1'b1;
        data_sram_data_ok = 1'b1;
        #1;
        check("fc_mdok", 32'(mem_data_ok), 32'd0);
        step();
        flush = 1'b0;
        data_sram_data_ok = 1'b0;
        #1;
        check("fc_cnt", 32'(discard_cnt), 32'd0);

        // new request accepted in the same cycle the previous response returns
        issue(1'b1, 1'b0, 2'b11, 32'h1C000300, 32'h0);
        data_sram_addr_ok = 1'b1;
        load_id(1'b1, 1'b0, 2'b11, 32'h1C000304, 32'h0);
        step();
        id_to_exe_valid = 1'b0;
        data_sram_data_ok = 1'b1;
        #1;
        check("sc_mdok", 32'(mem_data_ok), 32'd1);
        check("sc_req", 32'(data_sram_req), 32'd1);
        step();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check("sc_cnt1", 32'(discard_cnt), 32'd1);
        respond();
        #1;
        check("sc_cnt0", 32'(discard_cnt), 32'd0);

        // MEM backpressure, then addr_ok withheld for three cycles
        mem_allowin = 1'b0;
        issue(1'b1, 1'b0, 2'b10, 32'h1C000400, 32'h0);
        #1;
        check("bp_req", 32'(data_sram_req), 32'd0);
        check("bp_allowin", 32'(exe_allowin), 32'd0);
        step();
        mem_allowin = 1'b1;
        #1;
        check("bp_req_on", 32'(data_sram_req), 32'd1);
        check("bp_addr", data_sram_addr, 32'h1C000400);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold", 32'(exe_to_mem_valid), 32'd0);
        end
        data_sram_addr_ok = 1'b1;
        #1;
        check("bp_go", 32'(exe_to_mem_valid), 32'd1);
        step();
        data_sram_addr_ok = 1'b0;
        respond();

        // saturate the discard counter, drain one, then reset mid-sequence
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 1'b0, 2'b11, 32'h1C000500 + 32'(i * 4), 32'h0);
            data_sram_addr_ok = 1'b1;
            step();
            data_sram_addr_ok = 1'b0;
            flush = 1'b1;
            step();
            flush = 1'b0;
        end
        #1;
        check("sat_cnt3", 32'(discard_cnt), 32'd3);
        issue(1'b1, 1'b0, 2'b11, 32'h1C000600, 32'h0);
        #1;
        check("sat_req", 32'(data_sram_req), 32'd0);
        check("sat_allowin", 32'(exe_allowin), 32'd0);
        data_sram_data_ok = 1'b1;
        #1;
        check("sat_mdok", 32'(mem_data_ok), 32'd0);
        step();
        data_sram_data_ok = 1'b0;
        #1;
        check("sat_cnt2", 32'(discard_cnt), 32'd2);
        check("sat_req_on", 32'(data_sram_req), 32'd1);
        data_sram_addr_ok = 1'b1;
        step();
        data_sram_addr_ok = 1'b0;
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        #1;
        check("mrst_cnt", 32'(discard_cnt), 32'd0);
        check("mrst_tomem", 32'(exe_to_mem_valid), 32'd0);
        check("mrst_allowin", 32'(exe_allowin), 32'd1);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
